// File: rtl/expression_scanner.sv
// Truth-table sequencer for the (~a|b) & (b|~c) expression stage.
// It walks all 8 input vectors, samples y after each settle window, and publishes summary results.
module expression_scanner #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic [3:0] ones_count,
  output logic       result_valid,
  output logic       is_tautology,
  output logic       is_contradiction
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] tt_q, tt_d;
  logic [3:0] ones_q, ones_d;
  logic       rv_q, rv_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (cnt_q == 4'd0 && idx_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    vec_d  = vec_q;
    tt_d   = tt_q;
    ones_d = ones_q;
    rv_d   = rv_q;
    if (state_q == IDLE && start) begin
      idx_d  = 3'd0;
      vec_d  = 3'd0;
      tt_d   = 8'h00;
      ones_d = 4'd0;
      rv_d   = 1'b0;
      cnt_d  = RELOAD;
    end else if (state_q == SCAN) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        tt_d[idx_q] = y;
        ones_d      = ones_q + {3'b000, y};
        if (idx_q != 3'd7) begin
          idx_d = idx_q + 3'd1;
          vec_d = idx_q + 3'd1;
          cnt_d = RELOAD;
        end else begin
          // Results become visible together with the done pulse.
          vec_d = 3'd0;
          rv_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= 3'd0;
      cnt_q  <= 4'd0;
      vec_q  <= 3'd0;
      tt_q   <= 8'h00;
      ones_q <= 4'd0;
      rv_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      tt_q   <= tt_d;
      ones_q <= ones_d;
      rv_q   <= rv_d;
    end
  end

  assign a                = vec_q[2];
  assign b                = vec_q[1];
  assign c                = vec_q[0];
  assign truth_table      = tt_q;
  assign ones_count       = ones_q;
  assign result_valid     = rv_q;
  assign is_tautology     = rv_q && (tt_q == 8'hFF);
  assign is_contradiction = rv_q && (tt_q == 8'h00);

endmodule

// File: tb/tb_expression_scanner.sv
// Directed bench for expression_scanner: one instance at SETTLE=1, one at SETTLE=3.
module tb_expression_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       reset1, start1, y1;
  logic       a1, b1, c1, busy1, done1, rv1, taut1, contra1;
  logic [7:0] tt1;
  logic [3:0] ones1;
  logic [1:0] y_mode;  // 0: expression, 1: tied high, 2: tied low

  logic       reset3, start3, y3;
  logic       a3, b3, c3, busy3, done3, rv3, taut3, contra3;
  logic [7:0] tt3;
  logic [3:0] ones3;

  assign y1 = (y_mode == 2'd0) ? ((~a1 | b1) & (b1 | ~c1)) : (y_mode == 2'd1);
  assign y3 = (~a3 | b3) & (b3 | ~c3);

  expression_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
    .truth_table(tt1), .ones_count(ones1), .result_valid(rv1),
    .is_tautology(taut1), .is_contradiction(contra1)
  );

  expression_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset3), .start(start3), .y(y3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3),
    .truth_table(tt3), .ones_count(ones3), .result_valid(rv3),
    .is_tautology(taut3), .is_contradiction(contra3)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; returns just after the accept edge E0.
  task automatic pulse_start1();
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    $display("txn: dut1 start accepted, vector=%0d busy=%0b", {a1, b1, c1}, busy1);
  endtask

  task automatic test_reset();
    reset1 = 1'b1; reset3 = 1'b1;
    step(2);
    checks++;
    if ({a1, b1, c1, busy1, done1, tt1, ones1, rv1, taut1, contra1} !== 19'd0) begin
      errors++;
      $display("FAIL reset_dut1: got a/b/c/busy/done/tt/ones/rv/t/c=%b want all zero",
               {a1, b1, c1, busy1, done1, tt1, ones1, rv1, taut1, contra1});
    end
    checks++;
    if ({a3, b3, c3, busy3, done3, tt3, ones3, rv3, taut3, contra3} !== 19'd0) begin
      errors++;
      $display("FAIL reset_dut3: got %b want all zero",
               {a3, b3, c3, busy3, done3, tt3, ones3, rv3, taut3, contra3});
    end
    reset1 = 1'b0; reset3 = 1'b0;
    step(1);
    $display("txn: reset released");
  endtask

  task automatic test_settle1();
    pulse_start1();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({a1, b1, c1, busy1, done1} !== {3'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL s1_vector%0d: got abc=%0d busy=%0b done=%0b want abc=%0d busy=1 done=0",
                 k, {a1, b1, c1}, busy1, done1, k);
      end
      step(1);
    end
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || {a1, b1, c1} !== 3'd0) begin
      errors++;
      $display("FAIL s1_done: got done=%0b busy=%0b abc=%0d want done=1 busy=0 abc=0",
               done1, busy1, {a1, b1, c1});
    end
    checks++;
    if (tt1 !== 8'hCD || ones1 !== 4'd5 || rv1 !== 1'b1 || taut1 !== 1'b0 || contra1 !== 1'b0) begin
      errors++;
      $display("FAIL s1_results: got tt=%h ones=%0d rv=%0b taut=%0b contra=%0b want cd 5 1 0 0",
               tt1, ones1, rv1, taut1, contra1);
    end
    $display("txn: dut1 scan done tt=%h ones=%0d", tt1, ones1);
    step(1);
    checks++;
    if (done1 !== 1'b0 || tt1 !== 8'hCD || rv1 !== 1'b1) begin
      errors++;
      $display("FAIL s1_hold: got done=%0b tt=%h rv=%0b want done=0 tt=cd rv=1", done1, tt1, rv1);
    end
  endtask

  task automatic test_settle3();
    start3 = 1'b1;
    step(1);
    start3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 3; s++) begin
        checks++;
        if ({a3, b3, c3, busy3, done3} !== {3'(k), 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL s3_vector%0d_%0d: got abc=%0d busy=%0b done=%0b want abc=%0d busy=1 done=0",
                   k, s, {a3, b3, c3}, busy3, done3, k);
        end
        step(1);
      end
    end
    checks++;
    if (done3 !== 1'b1 || busy3 !== 1'b0 || tt3 !== 8'hCD || ones3 !== 4'd5) begin
      errors++;
      $display("FAIL s3_done: got done=%0b busy=%0b tt=%h ones=%0d want 1 0 cd 5",
               done3, busy3, tt3, ones3);
    end
    $display("txn: dut3 scan done tt=%h ones=%0d", tt3, ones3);
    step(1);
  endtask

  task automatic test_tied();
    y_mode = 2'd1;
    pulse_start1();
    step(8);
    checks++;
    if (done1 !== 1'b1 || tt1 !== 8'hFF || ones1 !== 4'd8 || taut1 !== 1'b1 || contra1 !== 1'b0) begin
      errors++;
      $display("FAIL tied1: got done=%0b tt=%h ones=%0d taut=%0b contra=%0b want 1 ff 8 1 0",
               done1, tt1, ones1, taut1, contra1);
    end
    $display("txn: tied-high scan tt=%h ones=%0d", tt1, ones1);
    step(1);
    y_mode = 2'd2;
    pulse_start1();
    checks++;
    if (rv1 !== 1'b0 || tt1 !== 8'h00 || taut1 !== 1'b0) begin
      errors++;
      $display("FAIL clear_on_start: got rv=%0b tt=%h taut=%0b want 0 00 0", rv1, tt1, taut1);
    end
    step(8);
    checks++;
    if (done1 !== 1'b1 || tt1 !== 8'h00 || ones1 !== 4'd0 || taut1 !== 1'b0 || contra1 !== 1'b1) begin
      errors++;
      $display("FAIL tied0: got done=%0b tt=%h ones=%0d taut=%0b contra=%0b want 1 00 0 0 1",
               done1, tt1, ones1, taut1, contra1);
    end
    $display("txn: tied-low scan tt=%h ones=%0d", tt1, ones1);
    step(1);
    y_mode = 2'd0;
  endtask

  task automatic test_start_while_busy();
    int done_seen;
    done_seen = 0;
    pulse_start1();
    step(3);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    checks++;
    if ({a1, b1, c1} !== 3'd4 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_vector: got abc=%0d busy=%0b want 4 1", {a1, b1, c1}, busy1);
    end
    for (int k = 4; k < 8; k++) begin
      if (done1) done_seen++;
      step(1);
    end
    checks++;
    if (done1 !== 1'b1 || done_seen != 0 || tt1 !== 8'hCD || ones1 !== 4'd5) begin
      errors++;
      $display("FAIL busy_start_done: got done=%0b early=%0d tt=%h ones=%0d want 1 0 cd 5",
               done1, done_seen, tt1, ones1);
    end
    step(1);
    step(1);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_queued: got busy=%0b done=%0b want 0 0", busy1, done1);
    end
    $display("txn: start while busy ignored tt=%h", tt1);
  endtask

  task automatic test_reset_mid_scan();
    pulse_start1();
    step(5);
    reset1 = 1'b1;
    step(1);
    checks++;
    if ({a1, b1, c1, busy1, done1, tt1, ones1, rv1, taut1, contra1} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b want all zero",
               {a1, b1, c1, busy1, done1, tt1, ones1, rv1, taut1, contra1});
    end
    reset1 = 1'b0;
    step(1);
    checks++;
    if (done1 !== 1'b0 || rv1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_after: got done=%0b rv=%0b want 0 0", done1, rv1);
    end
    pulse_start1();
    step(8);
    checks++;
    if (done1 !== 1'b1 || tt1 !== 8'hCD || ones1 !== 4'd5) begin
      errors++;
      $display("FAIL post_reset_scan: got done=%0b tt=%h ones=%0d want 1 cd 5", done1, tt1, ones1);
    end
    $display("txn: scan after mid-scan reset tt=%h", tt1);
    step(1);
  endtask

  task automatic test_back_to_back();
    start1 = 1'b1;
    step(1);
    for (int n = 0; n < 30; n++) begin
      checks++;
      if (done1 !== (n % 10 == 8) || rv1 !== (n % 10 >= 8) || busy1 !== (n % 10 <= 7)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got done=%0b rv=%0b busy=%0b want %0b %0b %0b",
                 n, done1, rv1, busy1, (n % 10 == 8), (n % 10 >= 8), (n % 10 <= 7));
      end
      if (done1) $display("txn: back-to-back done at cycle %0d tt=%h", n, tt1);
      step(1);
    end
    start1 = 1'b0;
    step(10);
  endtask

  initial begin
    reset1 = 1'b1; reset3 = 1'b1;
    start1 = 1'b0; start3 = 1'b0;
    y_mode = 2'd0;
    test_reset();
    test_settle1();
    test_settle3();
    test_tied();
    test_start_while_busy();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/expression_scanner.md
# expression_scanner

Sequential truth-table sequencer that drives the three inputs of the combinational expression stage `(~a|b) & (b|~c)` and consumes its output `y`. On a start request it walks all 8 input vectors, holds each for a programmable settle window, and samples `y` at the end of each window. It then publishes the 8-bit truth table, a ones count and tautology/contradiction flags. It wraps the expression block for self-test and characterisation.

## Interface
- `SETTLE`, default 1: cycles each vector is held before `y` is sampled; legal range 1..15.
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: scan request, level-sampled; accepted only in IDLE.
- `y` input 1: expression output, combinational from `a`, `b`, `c`.
- `a` output 1: expression input, MSB of vector index.
- `b` output 1: expression input, middle bit of vector index.
- `c` output 1: expression input, LSB of vector index.
- `busy` output 1: high while a scan is in progress.
- `done` output 1: one-cycle pulse when the scan completes.
- `truth_table` output 8: bit k = sampled `y` for vector k = {a,b,c}.
- `ones_count` output 4: number of 1 bits in `truth_table`, range 0..8.
- `result_valid` output 1: results are from a completed scan.
- `is_tautology` output 1: `result_valid` and `truth_table`==8'hFF.
- `is_contradiction` output 1: `result_valid` and `truth_table`==8'h00.

## Operation
- States:
  - IDLE: waits for `start`.
  - SCAN: steps through vectors 0..7.
  - DONE: lasts one cycle, then returns to IDLE.
- Internal registers:
  - `idx` 3 bits.
  - settle counter 4 bits.
- IDLE with `start`=1 sets:
  - `idx`=0, {a,b,c}=000.
  - `truth_table`=0, `ones_count`=0, `result_valid`=0.
  - settle counter=SETTLE-1.
  - state goes to SCAN.
- SCAN, counter≠0: decrement counter; vector held.
- SCAN, counter==0: sample `y`, then:
  - `truth_table[idx]`<=y.
  - `ones_count`<=`ones_count`+y.
  - If `idx`<7: `idx`++, {a,b,c}<=`idx`+1, counter reloads SETTLE-1.
  - If `idx`==7: state goes to DONE, {a,b,c}<=000.
- DONE: `done`=1, `result_valid`<=1, then IDLE.
- `start` is ignored in SCAN and DONE. No queuing.
- `start` held high in IDLE after DONE begins a new scan; the previous results are cleared at that edge.
- {a,b,c} are registered outputs, so the expression stage sees a glitch-free vector for the whole window.
- Reset, at any time including mid-scan, applies the reset values below. An aborted scan produces no `done` and no partial `result_valid`.

## Timing
- Reset values: state IDLE, `a`=`b`=`c`=0, `busy`=0, `done`=0, `truth_table`=0, `ones_count`=0, `result_valid`=0, both flags 0.
- Let E0 be the edge at which `start` is accepted.
- `busy`=1 from after E0 until after edge E(8·SETTLE).
- Vector k is driven from after E(k·SETTLE) through edge E((k+1)·SETTLE); `y` is sampled at that edge.
- `done`=1 exactly for the cycle after E(8·SETTLE), with `busy`=0 in that cycle.
  - `truth_table`, `ones_count`, `result_valid` and the flags are valid in the same cycle and hold until the next accepted start or reset.
- Scan latency from the accept edge to `done`: 8·SETTLE+1 cycles.
- Minimum start-to-start spacing: 8·SETTLE+2 cycles (DONE always consumes one cycle).

## Test plan
- SETTLE=1, reference expression connected, `start` pulsed one cycle. Required:
  - {a,b,c} steps 000→111, one vector per cycle.
  - `done` in cycle 9 after E0.
  - `truth_table`=8'hCD, `ones_count`=5, both flags 0.
- SETTLE=3, same expression. Required:
  - Each vector held 3 cycles.
  - `done` 25 cycles after E0.
  - `truth_table`=8'hCD.
- `y` tied to 1, then to 0. Required:
  - Tied to 1: `truth_table`=8'hFF, `ones_count`=8, `is_tautology`=1.
  - Tied to 0: `truth_table`=8'h00, `ones_count`=0, `is_contradiction`=1.
- `start` re-asserted while `busy` (vector 3). Required:
  - Scan unaffected.
  - Single `done` at the original cycle.
  - Results unchanged.
- `reset` asserted during vector 5. Required:
  - Next cycle all outputs at reset values, no `done`.
  - A new start afterwards yields 8'hCD.
- `start` held high continuously. Required:
  - Back-to-back scans, `done` every 10 cycles at SETTLE=1.
  - `result_valid` drops at each re-accept and rises with each `done`.
